sw_alloc: RTL and testbench

SW_ALLOC -- requirements
Module: sw_alloc

---
 rtl/noc_pkg.sv | 27 ++
 rtl/sw_alloc_rr_arb5.sv | 30 +++
 rtl/sw_alloc.sv | 162 ++++++++++++++++
 tb/tb_sw_alloc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port encoding, per-output FSM states and
// the round-robin index helper used by the switch allocator.
package noc_pkg;

  localparam int NUM_PORTS         = 5;
  localparam int PORT_W            = 3;
  localparam int DEFAULT_BUF_DEPTH = 4;

  typedef enum logic [PORT_W-1:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } out_state_e;

  // Successor of a port index, wrapping 4 -> 0.
  function automatic logic [PORT_W-1:0] nextPort(input logic [PORT_W-1:0] p);
    return (p >= PORT_W'(NUM_PORTS - 1)) ? '0 : p + PORT_W'(1);
  endfunction

endpackage

// File: rtl/sw_alloc_rr_arb5.sv
// Five-input round-robin arbiter: picks the first request at or after
// the pointer, wrapping 4 -> 0. Purely combinational.
module rr_arb5
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PORT_W-1:0]    ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PORT_W-1:0]    idx_o,
  output logic                 valid_o
);

  logic [PORT_W-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = ptr_i;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
      cand = nextPort(cand);
    end
  end

endmodule

// File: rtl/sw_alloc.sv
// Wormhole switch allocator: one IDLE/LOCKED FSM, owner, round-robin
// pointer and credit counter per output port; grants are combinational.
module sw_alloc
  import noc_pkg::*;
#(
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_valid_i,
  input  logic [PORT_W-1:0]    req_port_addr1_i,
  input  logic [PORT_W-1:0]    req_port_addr2_i,
  input  logic [PORT_W-1:0]    req_port_addr3_i,
  input  logic [PORT_W-1:0]    req_port_addr4_i,
  input  logic [PORT_W-1:0]    req_port_addr5_i,
  input  logic [NUM_PORTS-1:0] req_tail_i,
  input  logic                 credit_en_north,
  input  logic                 credit_en_south,
  input  logic                 credit_en_east,
  input  logic                 credit_en_west,
  input  logic                 credit_en_local,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 grant_access_north,
  output logic                 grant_access_south,
  output logic                 grant_access_east,
  output logic                 grant_access_west,
  output logic                 grant_access_local,
  output logic [PORT_W-1:0]    xbar_sel_north,
  output logic [PORT_W-1:0]    xbar_sel_south,
  output logic [PORT_W-1:0]    xbar_sel_east,
  output logic [PORT_W-1:0]    xbar_sel_west,
  output logic [PORT_W-1:0]    xbar_sel_local
);

  localparam int            CW   = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [PORT_W-1:0]    reqAddr   [NUM_PORTS];
  logic [NUM_PORTS-1:0] creditEn;
  logic [NUM_PORTS-1:0] gntPer    [NUM_PORTS];
  logic [PORT_W-1:0]    selPer    [NUM_PORTS];
  logic [NUM_PORTS-1:0] accessPer;

  assign reqAddr[0] = req_port_addr1_i;
  assign reqAddr[1] = req_port_addr2_i;
  assign reqAddr[2] = req_port_addr3_i;
  assign reqAddr[3] = req_port_addr4_i;
  assign reqAddr[4] = req_port_addr5_i;

  assign creditEn = {credit_en_local, credit_en_west, credit_en_east,
                     credit_en_south, credit_en_north};

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    out_state_e           state_q, state_d;
    logic [PORT_W-1:0]    owner_q, owner_d;
    logic [PORT_W-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]        credit_q, credit_d;
    logic [NUM_PORTS-1:0] reqVec;
    logic [NUM_PORTS-1:0] arbGnt;
    logic [PORT_W-1:0]    arbIdx;
    logic                 arbValid;
    logic                 creditOk;
    logic                 grant;
    logic [NUM_PORTS-1:0] gntVec;
    logic [PORT_W-1:0]    selIdx;

    // Addresses 5-7 never match an output, so they are dropped here.
    always_comb begin
      reqVec = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        reqVec[i] = req_valid_i[i] && (reqAddr[i] == PORT_W'(o));
      end
    end

    assign creditOk = (credit_q != '0);

    rr_arb5 u_arb (
      .req_i   (reqVec & {NUM_PORTS{creditOk}}),
      .ptr_i   (ptr_q),
      .gnt_o   (arbGnt),
      .idx_o   (arbIdx),
      .valid_o (arbValid)
    );

    always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      grant    = 1'b0;
      gntVec   = '0;
      selIdx   = '0;
      if (state_q == IDLE) begin
        if (arbValid) begin
          grant  = 1'b1;
          gntVec = arbGnt;
          selIdx = arbIdx;
          if (req_tail_i[arbIdx]) begin
            ptr_d = nextPort(arbIdx);
          end else begin
            state_d = LOCKED;
            owner_d = arbIdx;
          end
        end
      end else begin
        if (creditOk && reqVec[owner_q]) begin
          grant          = 1'b1;
          gntVec[owner_q] = 1'b1;
          selIdx         = owner_q;
          if (req_tail_i[owner_q]) begin
            state_d = IDLE;
            ptr_d   = nextPort(owner_q);
          end
        end
      end
      // A grant and a returned credit in the same cycle cancel out.
      if (grant && !creditEn[o]) begin
        credit_d = credit_q - CW'(1);
      end else if (!grant && creditEn[o] && (credit_q != FULL)) begin
        credit_d = credit_q + CW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= IDLE;
        owner_q  <= '0;
        ptr_q    <= '0;
        credit_q <= FULL;
      end else begin
        state_q  <= state_d;
        owner_q  <= owner_d;
        ptr_q    <= ptr_d;
        credit_q <= credit_d;
      end
    end

    assign gntPer[o]    = rst ? '0 : gntVec;
    assign selPer[o]    = rst ? '0 : selIdx;
    assign accessPer[o] = grant && !rst;
  end

  always_comb begin
    gnt_o = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_o = gnt_o | gntPer[o];
    end
  end

  assign grant_access_north = accessPer[NORTH];
  assign grant_access_south = accessPer[SOUTH];
  assign grant_access_east  = accessPer[EAST];
  assign grant_access_west  = accessPer[WEST];
  assign grant_access_local = accessPer[LOCAL];

  assign xbar_sel_north = selPer[NORTH];
  assign xbar_sel_south = selPer[SOUTH];
  assign xbar_sel_east  = selPer[EAST];
  assign xbar_sel_west  = selPer[WEST];
  assign xbar_sel_local = selPer[LOCAL];

endmodule

// File: tb/tb_sw_alloc.sv
// Directed scoreboard bench for sw_alloc: each cycle's expected grants are
// queued by the stimulus and popped by a monitor sampling on the falling edge.
module tb_sw_alloc;
  import noc_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_PORTS-1:0] reqValid;
  logic [NUM_PORTS-1:0] reqTail;
  logic [PORT_W-1:0]    reqAddr [NUM_PORTS];
  logic [NUM_PORTS-1:0] creditEn;
  logic [NUM_PORTS-1:0] gnt;
  logic                 gaN, gaS, gaE, gaW, gaL;
  logic [PORT_W-1:0]    selN, selS, selE, selW, selL;

  typedef struct {
    string                name;
    logic [NUM_PORTS-1:0] gnt;
    logic [NUM_PORTS-1:0] acc;
    logic [14:0]          sel;
  } exp_t;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sw_alloc #(.BUF_DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (reqValid),
    .req_port_addr1_i   (reqAddr[0]),
    .req_port_addr2_i   (reqAddr[1]),
    .req_port_addr3_i   (reqAddr[2]),
    .req_port_addr4_i   (reqAddr[3]),
    .req_port_addr5_i   (reqAddr[4]),
    .req_tail_i         (reqTail),
    .credit_en_north    (creditEn[0]),
    .credit_en_south    (creditEn[1]),
    .credit_en_east     (creditEn[2]),
    .credit_en_west     (creditEn[3]),
    .credit_en_local    (creditEn[4]),
    .gnt_o              (gnt),
    .grant_access_north (gaN),
    .grant_access_south (gaS),
    .grant_access_east  (gaE),
    .grant_access_west  (gaW),
    .grant_access_local (gaL),
    .xbar_sel_north     (selN),
    .xbar_sel_south     (selS),
    .xbar_sel_east      (selE),
    .xbar_sel_west      (selW),
    .xbar_sel_local     (selL)
  );

  task automatic clearInputs();
    reqValid = '0;
    reqTail  = '0;
    creditEn = '0;
    for (int i = 0; i < NUM_PORTS; i++) reqAddr[i] = '0;
  endtask

  // inp is the 1-based input port number.
  task automatic setReq(input int inp, input logic [PORT_W-1:0] addr, input logic tail);
    reqValid[inp-1] = 1'b1;
    reqAddr[inp-1]  = addr;
    reqTail[inp-1]  = tail;
  endtask

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic applyStimulus(input string name, input logic [NUM_PORTS-1:0] g,
                               input logic [NUM_PORTS-1:0] a, input logic [14:0] s);
    exp_t e;
    e.name = name;
    e.gnt  = g;
    e.acc  = a;
    e.sel  = s;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic applyGrant(input string name, input int outp, input int inp);
    logic [NUM_PORTS-1:0] g;
    logic [NUM_PORTS-1:0] a;
    logic [14:0]          s;
    g = '0;
    a = '0;
    s = '0;
    g[inp-1]          = 1'b1;
    a[outp]           = 1'b1;
    s[3*outp +: 3]    = PORT_W'(inp - 1);
    applyStimulus(name, g, a, s);
  endtask

  task automatic applyNone(input string name);
    applyStimulus(name, '0, '0, '0);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [NUM_PORTS-1:0] actAcc;
    logic [14:0]          actSel;
    actAcc = {gaL, gaW, gaE, gaS, gaN};
    actSel = {selL, selW, selE, selS, selN};
    vectors++;
    if (gnt !== e.gnt || actAcc !== e.acc || actSel !== e.sel) begin
      miscompares++;
      $display("[TB] FAIL %s: got gnt=%b acc=%b sel=%h, expected gnt=%b acc=%b sel=%h",
               e.name, gnt, actAcc, actSel, e.gnt, e.acc, e.sel);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    clearInputs();
    @(posedge clk);
    #1;

    // Reset holds all outputs low even with live requests.
    setReq(1, EAST, 1'b0); setReq(2, EAST, 1'b0);
    applyNone("reset_hold");
    rst = 1'b0;

    // Input 1 locks east with a 3-flit packet; input 2 waits.
    setReq(1, EAST, 1'b0); setReq(2, EAST, 1'b0);
    applyGrant("east_head_in1", EAST, 1);
    setReq(1, EAST, 1'b0); setReq(2, EAST, 1'b0);
    applyGrant("east_body_in1", EAST, 1);
    setReq(1, EAST, 1'b1); setReq(2, EAST, 1'b0);
    applyGrant("east_tail_in1", EAST, 1);
    // East credit now 1: grant plus credit return keeps it at 1.
    setReq(2, EAST, 1'b0); creditEn[EAST] = 1'b1;
    applyGrant("east_head_in2", EAST, 2);
    setReq(2, EAST, 1'b1);
    applyGrant("east_tail_in2", EAST, 2);
    setReq(1, EAST, 1'b1);
    applyNone("east_no_credit");
    setReq(1, EAST, 1'b1); creditEn[EAST] = 1'b1;
    applyNone("east_credit_latency");
    setReq(1, EAST, 1'b1);
    applyGrant("east_after_credit", EAST, 1);

    // Input 5 single-flit packets to north: four grants on full credit.
    for (int k = 0; k < 4; k++) begin
      setReq(5, NORTH, 1'b1);
      applyGrant("north_credit_grant", NORTH, 5);
    end
    setReq(5, NORTH, 1'b1);
    applyNone("north_stall_a");
    setReq(5, NORTH, 1'b1);
    applyNone("north_stall_b");
    setReq(5, NORTH, 1'b1); creditEn[NORTH] = 1'b1;
    applyNone("north_credit_return");
    setReq(5, NORTH, 1'b1);
    applyGrant("north_returned_grant", NORTH, 5);
    setReq(5, NORTH, 1'b1);
    applyNone("north_stall_c");

    // Credit return at full count saturates: still exactly four grants.
    creditEn[SOUTH] = 1'b1;
    applyNone("south_saturate_idle");
    for (int k = 0; k < 4; k++) begin
      setReq(3, SOUTH, 1'b1);
      applyGrant("south_saturated_grant", SOUTH, 3);
    end
    setReq(3, SOUTH, 1'b1);
    applyNone("south_no_overflow");

    // All inputs to local with continuous credit return: order 1..5,1.
    for (int k = 0; k < 6; k++) begin
      for (int i = 1; i <= NUM_PORTS; i++) setReq(i, LOCAL, 1'b1);
      creditEn[LOCAL] = 1'b1;
      applyGrant("local_rr_order", LOCAL, (k % 5) + 1);
    end

    // Invalid addresses are ignored; a valid west request still wins.
    setReq(1, 3'd6, 1'b1); setReq(2, 3'd7, 1'b1);
    applyNone("invalid_addr");
    setReq(1, 3'd6, 1'b0); setReq(2, 3'd5, 1'b1); setReq(4, WEST, 1'b1);
    applyGrant("invalid_with_west", WEST, 4);

    // Lock north to input 3, then reset mid-packet.
    creditEn[NORTH] = 1'b1;
    applyNone("north_refill");
    setReq(3, NORTH, 1'b0);
    applyGrant("north_lock_in3", NORTH, 3);
    setReq(1, NORTH, 1'b0);
    applyNone("north_locked_stall");
    rst = 1'b1;
    setReq(1, NORTH, 1'b0); setReq(3, NORTH, 1'b0);
    applyNone("reset_mid_lock");
    rst = 1'b0;
    setReq(1, NORTH, 1'b0); setReq(3, NORTH, 1'b0);
    applyGrant("north_after_reset", NORTH, 1);
    setReq(2, NORTH, 1'b1); setReq(1, NORTH, 1'b0);
    applyGrant("north_relocked_in1", NORTH, 1);
    setReq(2, NORTH, 1'b1);
    applyNone("north_owner_absent");

    @(negedge clk);
    @(negedge clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
